// File: rtl/mul32.sv
// Two-stage pipelined 32x32 multiplier returning the low 32 bits of the product.
// Stage 1 registers the three 16x16 partial products that reach the low word; stage 2 sums them.
module mul32 (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] C
);

  logic [31:0] ll_full, lh_full, hl_full;
  logic [31:0] pp_ll;
  logic [15:0] pp_lh, pp_hl;
  logic [15:0] mid;

  // Ah*Bh only touches bits 32 and up, so it is never formed.
  assign ll_full = A[15:0]  * B[15:0];
  assign lh_full = A[15:0]  * B[31:16];
  assign hl_full = A[31:16] * B[15:0];

  // Cross terms land at bit 16, so only their low halves survive the truncation.
  assign mid = pp_lh + pp_hl;

  // rst_n is active-high despite its name.
  always_ff @(posedge CLK) begin
    if (rst_n) begin
      pp_ll <= '0;
      pp_lh <= '0;
      pp_hl <= '0;
      C     <= '0;
    end else begin
      pp_ll <= ll_full;
      pp_lh <= lh_full[15:0];
      pp_hl <= hl_full[15:0];
      C     <= pp_ll + {mid, 16'h0000};
    end
  end

endmodule

// File: tb/tb_mul32.sv
// Self-checking bench for mul32: directed literal cases plus a randomized run
// checked every cycle against an operand-history model of the pipeline.
module tb_mul32;

  logic        clk;
  logic        rst;
  logic [31:0] a, b;
  logic [31:0] c;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] hist_a[$];
  logic [31:0] hist_b[$];
  logic        hist_r[$];

  mul32 dut (
    .CLK   (clk),
    .rst_n (rst),
    .A     (a),
    .B     (b),
    .C     (c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] low_prod(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    return p[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Record what the DUT sees at every rising edge.
  always @(posedge clk) begin
    hist_a.push_back(a);
    hist_b.push_back(b);
    hist_r.push_back(rst);
  end

  // C after edge k is 0 if edge k was a reset; otherwise the product of the
  // operands seen at edge k-1, unless that edge was itself a reset.
  always @(negedge clk) begin
    int n;
    logic [31:0] exp;
    n = hist_r.size();
    if (n >= 1) begin
      if (hist_r[n-1]) begin
        chk("model", c, 32'd0);
      end else if (n >= 2) begin
        exp = hist_r[n-2] ? 32'd0 : low_prod(hist_a[n-2], hist_b[n-2]);
        chk("model", c, exp);
      end
    end
  end

  task automatic apply(input string name, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp);
    @(negedge clk);
    a = x;
    b = y;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk(name, c, exp);
  endtask

  initial begin
    rst = 1'b1;
    a   = 32'h12345678;
    b   = 32'h12345678;

    // Reset held for four edges keeps C at 0.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("reset_hold", c, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("release_first_edge", c, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("release_result", c, 32'h1DF4D840);

    for (int i = 1; i <= 10; i++)
      for (int j = 1; j <= 10; j++)
        apply("sweep", i, j, i * j);

    apply("wrap_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    apply("wrap_2p32", 32'h00010000, 32'h00010000, 32'h00000000);
    apply("cross_half", 32'h0001FFFF, 32'h00030002, 32'h0000FFFE);
    apply("msb_x2", 32'h80000000, 32'd2, 32'd0);
    apply("zero_a", 32'd0, $urandom, 32'd0);
    apply("pow2_shift", 32'h00000100, 32'h00FF00FF, 32'hFF00FF00);

    // Back-to-back operands produce back-to-back results.
    @(negedge clk); a = 32'd3;      b = 32'd5;
    @(negedge clk); a = 32'd100;    b = 32'd200;
    @(negedge clk); chk("b2b_0", c, 32'd15);
                    a = 32'h0000FFFF; b = 32'h0000FFFF;
    @(negedge clk); chk("b2b_1", c, 32'd20000);
    @(negedge clk); chk("b2b_2", c, 32'hFFFE0001);

    // Reset with work in flight: neither discarded product appears.
    @(negedge clk); a = 32'd7;  b = 32'd11;
    @(negedge clk); a = 32'd13; b = 32'd17; rst = 1'b1;
    @(negedge clk); chk("midrst_clear", c, 32'd0);
                    rst = 1'b0; a = 32'd19; b = 32'd23;
    @(negedge clk); chk("midrst_no_stale", c, 32'd0);
    @(negedge clk); chk("midrst_next", c, 32'd437);

    // Randomized run with occasional resets; the model checks every cycle.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      a   = $urandom;
      b   = (k % 7 == 0) ? ($urandom & 32'h0000FFFF) : $urandom;
      rst = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
